// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake bundle between the pipeline and the register scoreboard.
interface reg_scoreboard_if #(
   parameter int NREGS  = 16,
   parameter int PERF_W = 16
);
   localparam int IDX_W = $clog2(NREGS);

   logic              id_valid;
   logic [IDX_W-1:0]  id_src1;
   logic [IDX_W-1:0]  id_src2;
   logic              id_use1;
   logic              id_use2;
   logic [IDX_W-1:0]  id_dst;
   logic              id_wr;
   logic              id_ready;
   logic              stall;
   logic              wb_valid;
   logic [IDX_W-1:0]  wb_reg;
   logic              flush;
   logic [NREGS-1:0]  busy_mask;
   logic [PERF_W-1:0] stall_cycles;
   logic              err;

   modport master (
      output id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wr,
             wb_valid, wb_reg, flush,
      input  id_ready, stall, busy_mask, stall_cycles, err
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_use1, id_use2, id_dst, id_wr,
             wb_valid, wb_reg, flush,
      output id_ready, stall, busy_mask, stall_cycles, err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters, RAW/saturation stall with
// same-cycle writeback bypass, flush, saturating stall-cycle counter and sticky error.
module reg_scoreboard #(
   parameter int NREGS  = 16,
   parameter int CNT_W  = 2,
   parameter int PERF_W = 16
) (
   input logic             clk,
   input logic             rst,
   reg_scoreboard_if.slave bus
);
   localparam int IDX_W = $clog2(NREGS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NREGS-1:0][CNT_W-1:0] cnt_reg;
   logic [NREGS-1:0][CNT_W-1:0] cnt_next;
   logic [NREGS-1:0]            wb_hit;
   logic [NREGS-1:0]            inc_hit;
   logic [NREGS-1:0]            under;
   logic [NREGS-1:0]            eff_nz;
   logic [NREGS-1:0]            eff_full;
   logic [PERF_W-1:0]           stall_cycles_reg;
   logic [PERF_W-1:0]           stall_cycles_next;
   logic                        err_reg;
   logic                        err_next;
   logic                        raw;
   logic                        sat;
   logic                        ready_core;
   logic                        issue;
   logic                        stall_int;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign wb_hit[gi]   = 1'b0;
            assign inc_hit[gi]  = 1'b0;
            assign under[gi]    = 1'b0;
            assign eff_nz[gi]   = 1'b0;
            assign eff_full[gi] = 1'b0;
            assign cnt_next[gi] = '0;
         end else begin : g_live
            assign wb_hit[gi]   = bus.wb_valid && (bus.wb_reg == IDX_W'(gi));
            assign inc_hit[gi]  = issue && bus.id_wr && (bus.id_dst == IDX_W'(gi));
            assign under[gi]    = wb_hit[gi] && (cnt_reg[gi] == '0) && !inc_hit[gi];
            // A retiring last writer is already visible to decode through the regfile bypass.
            assign eff_nz[gi]   = (cnt_reg[gi] != '0) && !(wb_hit[gi] && (cnt_reg[gi] == CNT_W'(1)));
            assign eff_full[gi] = (cnt_reg[gi] == CNT_MAX) && !wb_hit[gi];
            assign cnt_next[gi] = bus.flush ? '0 :
                                  under[gi] ? '0 :
                                  cnt_reg[gi] + CNT_W'(inc_hit[gi]) - CNT_W'(wb_hit[gi]);
         end
         assign bus.busy_mask[gi] = (cnt_reg[gi] != '0);
      end
   endgenerate

   assign raw        = (bus.id_use1 && eff_nz[bus.id_src1]) || (bus.id_use2 && eff_nz[bus.id_src2]);
   assign sat        = bus.id_wr && (bus.id_dst != '0) && eff_full[bus.id_dst];
   assign ready_core = !raw && !sat && !bus.flush;
   // While reset is held the stage reports ready and never stalls.
   assign issue      = rst && bus.id_valid && ready_core;
   assign stall_int  = rst && bus.id_valid && !ready_core;

   assign stall_cycles_next = (stall_int && (stall_cycles_reg != '1)) ? stall_cycles_reg + PERF_W'(1)
                                                                     : stall_cycles_reg;
   assign err_next = err_reg || (|under) || (!bus.flush && sat && bus.id_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg          <= '0;
         stall_cycles_reg <= '0;
         err_reg          <= 1'b0;
      end else begin
         cnt_reg          <= cnt_next;
         stall_cycles_reg <= stall_cycles_next;
         err_reg          <= err_next;
      end
   end

   assign bus.id_ready     = !rst || ready_core;
   assign bus.stall        = stall_int;
   assign bus.stall_cycles = stall_cycles_reg;
   assign bus.err          = err_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// checked against a counter-array reference model.
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   reg_scoreboard_if #(.NREGS(16), .PERF_W(16)) bus ();

   reg_scoreboard #(.NREGS(16), .CNT_W(2), .PERF_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // reference model state
   int   m_cnt [16];
   bit   m_err;
   int   m_stall;
   bit   exp_ready;
   logic obs_ready;
   logic obs_stall;

   function automatic int m_hit(int r);
      return (bus.wb_valid && (int'(bus.wb_reg) == r) && r != 0) ? 1 : 0;
   endfunction

   function automatic int m_eff(int r);
      return m_cnt[r] - m_hit(r);
   endfunction

   function automatic bit m_sat();
      return bus.id_wr && bus.id_dst != 0 && m_eff(int'(bus.id_dst)) == 3;
   endfunction

   function automatic bit m_ready();
      bit raw;
      raw = (bus.id_use1 && m_eff(int'(bus.id_src1)) != 0) ||
            (bus.id_use2 && m_eff(int'(bus.id_src2)) != 0);
      return !(raw || m_sat() || bus.flush);
   endfunction

   function automatic logic [15:0] m_busy();
      logic [15:0] m;
      m = '0;
      for (int r = 0; r < 16; r++) m[r] = (m_cnt[r] != 0);
      return m;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_err   = 1'b0;
      m_stall = 0;
   endtask

   task automatic apply(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                        input int d, input bit w, input bit wv, input int wr, input bit fl);
      @(negedge clk);
      bus.id_valid = v;   bus.id_src1 = 4'(s1); bus.id_use1 = u1;
      bus.id_src2  = 4'(s2); bus.id_use2 = u2;
      bus.id_dst   = 4'(d);  bus.id_wr = w;
      bus.wb_valid = wv;  bus.wb_reg = 4'(wr); bus.flush = fl;
      #1;
      exp_ready = m_ready();
      obs_ready = bus.id_ready;
      obs_stall = bus.stall;
   endtask

   task automatic tick();
      bit issue, inc, sat;
      int hit, nv;
      @(posedge clk);
      issue = bus.id_valid && exp_ready;
      sat   = m_sat();
      if (bus.id_valid && !exp_ready && m_stall < 65535) m_stall++;
      if (!bus.flush && sat && bus.id_valid) m_err = 1'b1;
      for (int r = 1; r < 16; r++) begin
         inc = issue && bus.id_wr && int'(bus.id_dst) == r;
         hit = m_hit(r);
         nv  = m_cnt[r] + (inc ? 1 : 0) - hit;
         if (nv < 0) begin nv = 0; m_err = 1'b1; end
         m_cnt[r] = bus.flush ? 0 : nv;
      end
      #1;
   endtask

   task automatic idle();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.id_valid = 0; bus.id_src1 = 0; bus.id_use1 = 0; bus.id_src2 = 0; bus.id_use2 = 0;
      bus.id_dst = 0; bus.id_wr = 0; bus.wb_valid = 0; bus.wb_reg = 0; bus.flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.id_valid = 1; bus.id_wr = 1; bus.id_dst = 4'd3; bus.id_use1 = 0; bus.id_use2 = 0;
      bus.wb_valid = 0; bus.flush = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.wb_reg = 0;
      @(posedge clk); #1;
      checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.id_ready); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL reset_busy: got %h expected 0000", bus.busy_mask); end
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      do_reset();
   endtask

   task automatic test_raw();
      do_reset();
      apply(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b expected 1", obs_ready); end
      tick();
      checks++; if (bus.busy_mask !== 16'h0008) begin errors++; $display("FAIL raw_busy: got %h expected 0008", bus.busy_mask); end
      for (int i = 1; i <= 3; i++) begin
         apply(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
         checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL raw_stall%0d: got %b expected 1", i, obs_stall); end
         tick();
         checks++; if (bus.stall_cycles !== 16'(i)) begin errors++; $display("FAIL raw_stall_cycles: got %0d expected %0d", bus.stall_cycles, i); end
      end
   endtask

   task automatic test_bypass();
      do_reset();
      apply(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      tick();
      apply(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", obs_ready); end
      tick();
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL bypass_busy: got %h expected 0000", bus.busy_mask); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bypass_err: got %b expected 0", bus.err); end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (3) begin apply(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick(); end
      checks++; if (bus.busy_mask !== 16'h0020) begin errors++; $display("FAIL sat_busy: got %h expected 0020", bus.busy_mask); end
      apply(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b expected 1", obs_stall); end
      tick();
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sat_err: got %b expected 1", bus.err); end
      apply(1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL sat_wb_ready: got %b expected 1", obs_ready); end
      tick();
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sat_err_sticky: got %b expected 1", bus.err); end
      apply(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL sat_still_full: got %b expected 1", obs_stall); end
      tick();
   endtask

   task automatic test_same_cycle();
      do_reset();
      apply(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      tick();
      apply(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", obs_ready); end
      tick();
      checks++; if (bus.busy_mask !== 16'h0080) begin errors++; $display("FAIL same_busy: got %h expected 0080", bus.busy_mask); end
      apply(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      tick();
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL same_count_one: got %h expected 0000", bus.busy_mask); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL same_err: got %b expected 0", bus.err); end
   endtask

   task automatic test_flush();
      do_reset();
      apply(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
      apply(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
      apply(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); tick();
      checks++; if (bus.busy_mask !== 16'h0214) begin errors++; $display("FAIL flush_pre_busy: got %h expected 0214", bus.busy_mask); end
      apply(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", obs_ready); end
      tick();
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL flush_busy: got %h expected 0000", bus.busy_mask); end
      checks++; if (bus.stall_cycles !== 16'd1) begin errors++; $display("FAIL flush_stall_cycles: got %0d expected 1", bus.stall_cycles); end
   endtask

   task automatic test_underflow_r0();
      do_reset();
      apply(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
      tick();
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b expected 1", bus.err); end
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL underflow_busy: got %h expected 0000", bus.busy_mask); end
      apply(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b expected 1", obs_ready); end
      tick();
      apply(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL r0_read_ready: got %b expected 1", obs_ready); end
      tick();
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL r0_busy: got %h expected 0000", bus.busy_mask); end
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
      apply(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
      apply(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL areset_pre_stall: got %b expected 1", obs_stall); end
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL areset_stall: got %b expected 0", bus.stall); end
      checks++; if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", bus.id_ready); end
      checks++; if (bus.busy_mask !== 16'h0000) begin errors++; $display("FAIL areset_busy: got %h expected 0000", bus.busy_mask); end
      checks++; if (bus.stall_cycles !== 16'd0) begin errors++; $display("FAIL areset_stall_cycles: got %0d expected 0", bus.stall_cycles); end
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      apply(1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL areset_first_issue: got %b expected 1", obs_ready); end
      tick();
      checks++; if (bus.busy_mask !== 16'h0008) begin errors++; $display("FAIL areset_post_busy: got %h expected 0008", bus.busy_mask); end
   endtask

   task automatic test_random();
      int wr;
      bit wv;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         wr = int'($urandom_range(15, 0));
         wv = ($urandom_range(1, 0) == 1) && (m_cnt[wr] != 0);
         apply($urandom_range(3, 0) != 0,
               int'($urandom_range(15, 0)), $urandom_range(1, 0) == 1,
               int'($urandom_range(15, 0)), $urandom_range(1, 0) == 1,
               int'($urandom_range(15, 0)), $urandom_range(1, 0) == 1,
               wv, wr, $urandom_range(31, 0) == 0);
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready); end
         checks++; if (obs_stall !== (bus.id_valid && !exp_ready)) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, obs_stall, bus.id_valid && !exp_ready); end
         tick();
         checks++; if (bus.busy_mask !== m_busy()) begin errors++; $display("FAIL rand_busy[%0d]: got %h expected %h", i, bus.busy_mask, m_busy()); end
         checks++; if (bus.stall_cycles !== 16'(m_stall)) begin errors++; $display("FAIL rand_stall_cycles[%0d]: got %0d expected %0d", i, bus.stall_cycles, m_stall); end
         checks++; if (bus.err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, bus.err, m_err); end
      end
   endtask

   initial begin
      rst = 1'b0;
      model_clear();
      test_reset();
      test_raw();
      test_bypass();
      test_saturation();
      test_same_cycle();
      test_flush();
      test_underflow_r0();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-dependency scoreboard and stall controller in front of the decode/register-file stage of the 16-bit pipeline.
- Tracks in-flight writes to the 16 architectural registers using a per-register pending counter.
- Withholds issue (stall) while an instruction reads a register with an outstanding write.
- Releases registers on writeback, supports pipeline flush, and keeps a stall-cycle performance counter and a sticky protocol-error flag.

Parameters:
NREGS, 16, number of architectural registers (register index width = log2(NREGS) = 4)
CNT_W, 2, width of each per-register pending counter (max 3 outstanding writers per register)
PERF_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
id_valid  input  1  decode holds a valid instruction
id_src1  input  4  first source register (instr[7:4])
id_src2  input  4  second source register (instr[3:0], or instr[11:8] for store-type reads)
id_use1  input  1  instruction actually reads id_src1
id_use2  input  1  instruction actually reads id_src2
id_dst  input  4  destination register (instr[11:8])
id_wr  input  1  instruction writes id_dst
id_ready  output  1  instruction may issue this cycle
stall  output  1  id_valid & ~id_ready
wb_valid  input  1  a register write completes this cycle
wb_reg  input  4  register being written back
flush  input  1  squash all in-flight writers
busy_mask  output  16  bit r = pending count of register r is nonzero (registered state, pre-writeback)
stall_cycles  output  PERF_W  saturating count of cycles with stall=1
err  output  1  sticky: writeback to a register with count 0, or counter overflow attempt

Behaviour:
- Reset (rst=0, asynchronous):
  - all pending counters 0
  - busy_mask=0, stall_cycles=0, err=0
  - id_ready=1, stall=0 (id_valid has no effect while in reset)
- Register 0 is hardwired zero:
  - never marked pending
  - reads of R0 never hazard
  - id_wr with id_dst=0 does not increment
- wb_hit[r] = wb_valid & (wb_reg==r) & (r!=0).
- Effective pending, eff[r] = cnt[r] - wb_hit[r], computed combinationally:
  - the register file write-before-read bypass makes a same-cycle writeback visible to decode
  - so a source whose last writer retires this cycle does not stall.
- Hazard:
  - raw = (id_use1 & eff[id_src1]!=0) | (id_use2 & eff[id_src2]!=0)
  - sat = id_wr & id_dst!=0 & eff[id_dst]==2^CNT_W-1
- id_ready = ~raw & ~sat & ~flush. Purely combinational, no cycle latency.
- Issue event: issue = id_valid & id_ready.
- Next counter value, per register:
  - flush=1 → 0 for every register; flush dominates issue and writeback.
  - otherwise cnt + (issue & id_wr & id_dst==r) - wb_hit[r]
  - simultaneous issue and writeback to the same register leaves the count unchanged
- WAW is allowed: multiple outstanding writers up to the saturation limit; writebacks are in order by pipeline construction.
- Error conditions (err sticky until reset):
  - wb_hit on a register with cnt=0 and no same-cycle issue to it sets err; that counter stays 0 (no underflow).
  - flush=0 and sat=1 with id_valid sets err; that instruction is still held off.
- stall_cycles increments when stall=1, saturating at all-ones. Flush does not clear it.
- busy_mask is a direct decode of the registered counters.
- A reset asserted mid-operation discards all pending state immediately; on release, the first cycle with id_valid issues freely.

Test Plan:
- Reset then id_valid, id_wr=1, id_dst=3 → id_ready=1; next cycle busy_mask=0x0008. Then read src1=3, use1=1 → stall=1 each cycle; stall_cycles counts 1,2,3.
- R3 pending, count 1; apply wb_valid, wb_reg=3 in the same cycle as the dependent read → id_ready=1 that cycle, busy_mask=0x0000 next cycle.
- Three consecutive issues writing R5 with no writeback → cnt[5]=3. Fourth writer of R5 → stall=1, err=1. One wb to R5 in that cycle → issues, count remains 3, err stays 1.
- Issue writer of R7 with wb_reg=7 in the same cycle, count previously 1 → count stays 1, busy_mask bit7=1.
- R2, R4, R9 pending; assert flush with id_valid=1 → id_ready=0 that cycle, busy_mask=0 next cycle, no increment from the flushed issue.
- wb_valid to R6 with cnt 0 → err=1, cnt[6]=0. Writer to R0 → id_ready=1, busy_mask bit0 stays 0. Assert rst mid-stall → outputs return to reset values immediately, without waiting for a clock edge.
